master_port_sp: RTL

Bus-side master port that issues single read/write transactions to a slave and supports slave split responses. A local requester starts a transaction. The port requests the bus from the arbiter, drives mode/addr/wdata/valid once granted, and completes on `ready`. If the slave answers with `split`, the port releases the bus and resumes only when the arbiter re-grants it. The block is the master-side counterpart of the split-capable slave, and it sits between a master core and the shared bus/arbiter.

---
 rtl/master_port_sp.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/master_port_sp.sv
// master_port_sp: bus-side master port issuing single read/write transactions
// with support for slave split responses. A local requester starts a
// transaction; the port arbitrates for the bus, presents it, and reports
// completion. Optional timeout abort is enabled by defining the macro
// MASTER_SP_TIMEOUT_EN; without it the port waits in BUS indefinitely and
// req_err stays 0.
module master_port_sp #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_start,
    input  logic              req_mode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_busy,
    output logic              req_done,
    output logic              req_err,
    output logic [DATA_W-1:0] req_rdata,
    output logic              arb_req,
    input  logic              arb_grant,
    output logic              mode,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              valid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ready,
    input  logic              split
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_BUS,
        S_SPLIT_WAIT,
        S_DONE
    } state_t;

    state_t            r_state;
    logic              r_lat_mode;
    logic [ADDR_W-1:0] r_lat_addr;
    logic [DATA_W-1:0] r_lat_wdata;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_rdata;
    logic              r_arb_req;
    logic              r_mode;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_valid;

`ifdef MASTER_SP_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
    logic              r_err;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_inc;

    assign w_cnt_inc = r_cnt + 8'd1;
`endif

    // Transaction FSM; every output is a register updated alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lat_mode  <= 1'b0;
            r_lat_addr  <= '0;
            r_lat_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rdata     <= '0;
            r_arb_req   <= 1'b0;
            r_mode      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_valid     <= 1'b0;
`ifdef MASTER_SP_TIMEOUT_EN
            r_err       <= 1'b0;
            r_cnt       <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_start) begin
                        r_lat_mode  <= req_mode;
                        r_lat_addr  <= req_addr;
                        r_lat_wdata <= req_wdata;
                        r_arb_req   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (arb_grant) begin
                        r_mode  <= r_lat_mode;
                        r_addr  <= r_lat_addr;
                        r_wdata <= r_lat_wdata;
                        r_valid <= 1'b1;
                        r_state <= S_BUS;
`ifdef MASTER_SP_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                S_BUS: begin
                    if (ready) begin
                        if (!r_lat_mode) begin
                            r_rdata <= rdata;
                        end
                        r_valid   <= 1'b0;
                        r_arb_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
`ifdef MASTER_SP_TIMEOUT_EN
                        r_err     <= 1'b0;
`endif
                    end else if (split) begin
                        r_valid   <= 1'b0;
                        r_arb_req <= 1'b0;
                        r_state   <= S_SPLIT_WAIT;
`ifdef MASTER_SP_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                    end else if (!arb_grant) begin
                        // grant lost: keep requesting and retry the same fields
                        r_valid <= 1'b0;
                        r_state <= S_REQ;
                    end
`ifdef MASTER_SP_TIMEOUT_EN
                    else if (w_cnt_inc == TO_LIMIT) begin
                        r_valid   <= 1'b0;
                        r_arb_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
`endif
                end
                S_SPLIT_WAIT: begin
                    // arbiter re-grants a split master without a request
                    if (arb_grant) begin
                        r_mode    <= r_lat_mode;
                        r_addr    <= r_lat_addr;
                        r_wdata   <= r_lat_wdata;
                        r_valid   <= 1'b1;
                        r_arb_req <= 1'b1;
                        r_state   <= S_BUS;
`ifdef MASTER_SP_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_busy  = r_busy;
    assign req_done  = r_done;
    assign req_rdata = r_rdata;
    assign arb_req   = r_arb_req;
    assign mode      = r_mode;
    assign addr      = r_addr;
    assign wdata     = r_wdata;
    assign valid     = r_valid;
`ifdef MASTER_SP_TIMEOUT_EN
    assign req_err   = r_err;
`else
    assign req_err   = 1'b0;
`endif

endmodule
